copi_cipo_spi_engine: RTL and testbench

- Transmitting end of the headstage SPI link. Serializes 16-bit COPI command words onto CS_b/SCLK/COPI at 4 dataclk ticks per bit.
- Samples CIPO on every dataclk tick during each frame and its tail, producing the 74-sample 4x-oversampled vector consumed by the downstream phase selector.
- Sits between the command sequencer and the CIPO phase selection logic, one instance per SPI port.

---
 rtl/copi_cipo_spi_engine.sv | 134 +++++++++++++
 tb/tb_copi_cipo_spi_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/copi_cipo_spi_engine.sv
// SPI transmit engine: serializes 16-bit COPI commands and captures 4x-oversampled CIPO.
// Optional macro CIPO_LOOPBACK_EN adds loopback_en, sampling a 3-cycle delayed copy of copi.
module copi_cipo_spi_engine #(
   parameter int CS_HIGH_TICKS = 16,
   parameter int CAPTURE_LEN   = 74
) (
   input  logic                   dataclk,
   input  logic                   reset,
   input  logic [15:0]            cmd,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   output logic                   cs_b,
   output logic                   sclk,
   output logic                   copi,
   input  logic                   cipo,
`ifdef CIPO_LOOPBACK_EN
   input  logic                   loopback_en,
`endif
   output logic [CAPTURE_LEN-1:0] cipo4x,
   output logic                   cipo4x_valid
);

   generate
      if (CS_HIGH_TICKS < 10 || CS_HIGH_TICKS > 255) begin : g_bad_gap
         $error("copi_cipo_spi_engine: CS_HIGH_TICKS must be in 10..255");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, FRAME, TAIL, GAP} state_t;

   state_t                 state, state_n;
   logic [5:0]             t, t_n;
   logic [7:0]             h, h_n;
   logic [15:0]            cmd_q;
   logic                   cs_b_n, sclk_n, copi_n;
   logic [6:0]             s;
   logic                   samp_en, sample_bit, copy_pend;
   logic [CAPTURE_LEN-1:0] shadow;

   assign cmd_ready = (state == IDLE);

   // Output registers are loaded with the levels of the tick being entered.
   always_comb begin
      state_n = state;
      t_n     = t;
      h_n     = h;
      cs_b_n  = 1'b1;
      sclk_n  = 1'b0;
      copi_n  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_n = FRAME;
               t_n     = 6'd0;
               h_n     = 8'd0;
               cs_b_n  = 1'b0;
               copi_n  = cmd[15];
            end
         end
         FRAME: begin
            if (t == 6'd63) begin
               state_n = TAIL;
               h_n     = 8'd0;
            end else begin
               t_n    = t + 6'd1;
               cs_b_n = 1'b0;
               sclk_n = t_n[1];
               copi_n = cmd_q[~t_n[5:2]];
            end
         end
         TAIL, GAP: begin
            if (h == 8'(CS_HIGH_TICKS - 1)) begin
               state_n = IDLE;
               h_n     = 8'd0;
            end else begin
               h_n     = h + 8'd1;
               state_n = (h_n < 8'd10) ? TAIL : GAP;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge dataclk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         t     <= '0;
         h     <= '0;
         cmd_q <= '0;
         cs_b  <= 1'b1;
         sclk  <= 1'b0;
         copi  <= 1'b0;
      end else begin
         state <= state_n;
         t     <= t_n;
         h     <= h_n;
         cs_b  <= cs_b_n;
         sclk  <= sclk_n;
         copi  <= copi_n;
         if (state == IDLE && cmd_valid) cmd_q <= cmd;
      end
   end

`ifdef CIPO_LOOPBACK_EN
   logic [2:0] lb_dly;
   always_ff @(posedge dataclk or posedge reset) begin
      if (reset) lb_dly <= '0;
      else       lb_dly <= {lb_dly[1:0], copi};
   end
   assign sample_bit = loopback_en ? lb_dly[2] : cipo;
`else
   assign sample_bit = cipo;
`endif

   // Frame ticks map to samples 0..63, tail ticks to 64..73.
   assign samp_en = (state == FRAME) || (state == TAIL);
   assign s       = (state == FRAME) ? {1'b0, t} : 7'd64 + h[6:0];

   // The copy trails the last sample by one tick; it may land in IDLE when the gap is short.
   always_ff @(posedge dataclk or posedge reset) begin
      if (reset) begin
         shadow       <= '0;
         cipo4x       <= '0;
         cipo4x_valid <= 1'b0;
         copy_pend    <= 1'b0;
      end else begin
         cipo4x_valid <= copy_pend;
         copy_pend    <= samp_en && (s == 7'(CAPTURE_LEN - 1));
         if (copy_pend) cipo4x <= shadow;
         if (samp_en) shadow[s] <= sample_bit;
      end
   end

endmodule

// File: tb/tb_copi_cipo_spi_engine.sv
// Directed bench for copi_cipo_spi_engine: frame shape, capture, back-to-back timing, mid-frame reset.
module tb_copi_cipo_spi_engine;

   logic        dataclk = 1'b0;
   logic        reset   = 1'b1;
   logic [15:0] cmd     = '0;
   logic        cmd_valid = 1'b0;
   logic        cipo    = 1'b0;
   logic        loopback_en = 1'b0;
   logic        cmd_ready, cs_b, sclk, copi, cipo4x_valid;
   logic [73:0] cipo4x;

   copi_cipo_spi_engine #(.CS_HIGH_TICKS(16), .CAPTURE_LEN(74)) dut (
      .dataclk(dataclk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cs_b(cs_b), .sclk(sclk), .copi(copi), .cipo(cipo),
`ifdef CIPO_LOOPBACK_EN
      .loopback_en(loopback_en),
`endif
      .cipo4x(cipo4x), .cipo4x_valid(cipo4x_valid)
   );

   always #5 dataclk = ~dataclk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] cmd;
      int          mode;
      logic        lb;
      logic [15:0] exp_word;
      logic [73:0] exp_cap;
   } vec_t;

   vec_t tbl[$];

   function automatic logic pat(input int mode, input int k);
      case (mode)
         1:       return 1'b1;
         2:       return (k == 40);
         3:       return (k == 0) || (k == 73);
         default: return 1'b0;
      endcase
   endfunction

   int          low_cnt, nrise, ready_low, nvalid, rise_i, valid_i;
   logic        spacing_ok;
   logic [15:0] word;
   logic [73:0] cap;

   task automatic run_frame(input logic [15:0] c, input int mode, input logic lb);
      int   k, last_rise;
      logic prev_sclk, prev_cs;
      loopback_en = lb;
      @(negedge dataclk);
      for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge dataclk);
      chk("ready_wait", cmd_ready, 1'b1);
      cmd = c; cmd_valid = 1'b1;
      @(negedge dataclk);
      cmd_valid = 1'b0; cmd = ~c;
      k = -1; last_rise = -1; prev_sclk = 1'b0; prev_cs = 1'b1;
      low_cnt = 0; nrise = 0; ready_low = 0; nvalid = 0; rise_i = -1; valid_i = -1;
      spacing_ok = 1'b1; word = '0; cap = '0;
      for (int i = 0; i < 120; i++) begin
         if (k < 0 && !cs_b) k = 0;
         if (k >= 0 && k < 74) begin cipo = pat(mode, k); k++; end
         else cipo = 1'b0;
         if (!cs_b) low_cnt++;
         if (!cmd_ready) ready_low++;
         if (sclk && !prev_sclk) begin
            if (last_rise >= 0 && i - last_rise != 4) spacing_ok = 1'b0;
            last_rise = i;
            word = {word[14:0], copi};
            nrise++;
         end
         if (cs_b && !prev_cs && rise_i < 0) rise_i = i;
         if (cipo4x_valid) begin nvalid++; valid_i = i; cap = cipo4x; end
         prev_sclk = sclk; prev_cs = cs_b;
         @(negedge dataclk);
      end
      loopback_en = 1'b0;
   endtask

   task automatic check_frame(input vec_t v);
      chk("cs_low_cycles", low_cnt, 64);
      chk("sclk_rises", nrise, 16);
      chk("sclk_spacing", spacing_ok, 1'b1);
      chk("copi_word", word, v.exp_word);
      chk("ready_low_cycles", ready_low, 80);
      chk("valid_pulses", nvalid, 1);
      chk("valid_delay", valid_i - rise_i, 11);
      chk("cipo4x", cap, v.exp_cap);
   endtask

   initial begin
      int          falls[$];
      logic [15:0] w[4];
      int          nr;
      logic        prev_cs, prev_sclk;
      int          nv;
      vec_t        v;

      tbl.push_back('{16'hA5C3, 1, 1'b0, 16'hA5C3, {74{1'b1}}});
      tbl.push_back('{16'hA5C3, 0, 1'b0, 16'hA5C3, 74'd0});
      tbl.push_back('{16'h1234, 2, 1'b0, 16'h1234, 74'd1 << 40});
`ifdef CIPO_LOOPBACK_EN
      tbl.push_back('{16'h8001, 1, 1'b1, 16'h8001, (74'hF << 63) | 74'h78});
`endif
      tbl.push_back('{16'h0F0F, 3, 1'b0, 16'h0F0F, (74'd1 << 73) | 74'd1});

      // Reset state
      repeat (3) @(negedge dataclk);
      chk("rst_cs_b", cs_b, 1'b1);
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_copi", copi, 1'b0);
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_valid", cipo4x_valid, 1'b0);
      chk("rst_cipo4x", cipo4x, 74'd0);
      reset = 1'b0;

      foreach (tbl[n]) begin
         run_frame(tbl[n].cmd, tbl[n].mode, tbl[n].lb);
         check_frame(tbl[n]);
      end

      // Back-to-back with cmd_valid held; cmd changes mid-frame
      @(negedge dataclk);
      for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge dataclk);
      cmd = 16'h3C5A; cmd_valid = 1'b1;
      prev_cs = 1'b1; prev_sclk = 1'b0; nr = 0;
      foreach (w[j]) w[j] = '0;
      for (int i = 0; i < 260; i++) begin
         @(negedge dataclk);
         if (!cs_b && prev_cs) falls.push_back(i);
         if (falls.size() == 1 && i == falls[0] + 20) cmd = 16'hC0DE;
         if (sclk && !prev_sclk) begin
            if (nr / 16 < 4) w[nr/16] = {w[nr/16][14:0], copi};
            nr++;
         end
         prev_cs = cs_b; prev_sclk = sclk;
      end
      cmd_valid = 1'b0;
      chk("b2b_falls", falls.size() >= 3, 1'b1);
      if (falls.size() >= 3) begin
         chk("b2b_period0", falls[1] - falls[0], 81);
         chk("b2b_period1", falls[2] - falls[1], 81);
      end
      chk("b2b_word0", w[0], 16'h3C5A);
      chk("b2b_word1", w[1], 16'hC0DE);

      // Reset at tick 30 of a frame
      @(negedge dataclk);
      for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge dataclk);
      chk("mid_ready_wait", cmd_ready, 1'b1);
      cmd = 16'hFFFF; cmd_valid = 1'b1;
      @(negedge dataclk);
      cmd_valid = 1'b0; cipo = 1'b1;
      repeat (30) @(negedge dataclk);
      chk("mid_in_frame", cs_b, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid_rst_cs_b", cs_b, 1'b1);
      chk("mid_rst_sclk", sclk, 1'b0);
      chk("mid_rst_copi", copi, 1'b0);
      chk("mid_rst_ready", cmd_ready, 1'b1);
      chk("mid_rst_cipo4x", cipo4x, 74'd0);
      repeat (2) @(negedge dataclk);
      reset = 1'b0;
      nv = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge dataclk);
         if (cipo4x_valid) nv++;
      end
      cipo = 1'b0;
      chk("mid_no_valid", nv, 0);
      chk("mid_cipo4x_zero", cipo4x, 74'd0);
      chk("mid_cs_idle", cs_b, 1'b1);

      v = '{16'hA5C3, 1, 1'b0, 16'hA5C3, {74{1'b1}}};
      run_frame(v.cmd, v.mode, v.lb);
      check_frame(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
